// File: rtl/led_fader.sv
// LED cross-fader: accepts a 4-bit on/off pattern over valid/ready, ramps each
// channel's brightness linearly toward full on/off and drives the pins with PWM.
module led_fader #(
  parameter int N_LEDS      = 4,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] pat,
  input  logic              pat_valid,
  output logic              pat_ready,
  output logic              busy,
  output logic [N_LEDS-1:0] leds
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam int                  PS_W = $clog2(STEP_CYCLES);

  typedef enum logic {IDLE, FADE} state_t;

  state_t              state, next_state;
  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level   [N_LEDS];
  logic [PWM_BITS-1:0] target  [N_LEDS];
  logic [PWM_BITS-1:0] stepped [N_LEDS];
  logic                accept;
  logic                wrap;
  logic                req_match;
  logic                step_done;

  assign accept = pat_valid && pat_ready;
  assign wrap   = (prescaler == PS_W'(STEP_CYCLES - 1));

  // Each level moves one step toward its target; equal levels hold, so a
  // level can never overshoot or wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_match = 1'b1;
    step_done = 1'b1;
    for (int i = 0; i < N_LEDS; i++) begin
      stepped[i] = level[i];
      if (level[i] < target[i])
        stepped[i] = level[i] + PWM_BITS'(1);
      else if (level[i] > target[i])
        stepped[i] = level[i] - PWM_BITS'(1);
      if ((pat[i] ? MAX : '0) != level[i])
        req_match = 1'b0;
      if (stepped[i] != target[i])
        step_done = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && !req_match) next_state = FADE;
      FADE: if (wrap && step_done)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    pat_ready = (state == IDLE);
  end

  // Datapath: levels, targets, prescaler, PWM counter and registered outputs.
  // NOTE: level/target arrays are plain flops, not RAM, so they are reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      busy      <= 1'b0;
      leds      <= '0;
      for (int i = 0; i < N_LEDS; i++) begin
        level[i]  <= '0;
        target[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      busy    <= (next_state == FADE);
      if (accept) begin
        prescaler <= '0;
        for (int i = 0; i < N_LEDS; i++)
          target[i] <= pat[i] ? MAX : '0;
      end else if (state == FADE) begin
        prescaler <= wrap ? '0 : prescaler + PS_W'(1);
        if (wrap)
          for (int i = 0; i < N_LEDS; i++)
            level[i] <= stepped[i];
      end
      // Full scale is forced on so MAX has no one-cycle gap per PWM period.
      for (int i = 0; i < N_LEDS; i++)
        leds[i] <= (level[i] == MAX) ? 1'b1 : (pwm_cnt < level[i]);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Randomized scoreboard bench for led_fader (MAX=15, 4-cycle steps): a cycle
// model predicts leds/busy/pat_ready, a monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_led_fader;

  localparam int N        = 4;
  localparam int PB       = 4;
  localparam int STEP     = 4;
  localparam int MAXL     = (1 << PB) - 1;
  localparam int PERIOD   = 10;
  localparam int BUDGET   = 200;

  typedef struct {
    logic [N-1:0] leds;
    logic         busy;
    logic         ready;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pat = '0;
  logic         pat_valid = 1'b0;
  logic         pat_ready;
  logic         busy;
  logic [N-1:0] leds;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  led_fader #(.N_LEDS(N), .PWM_BITS(PB), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst(rst), .pat(pat), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .busy(busy), .leds(leds)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a fade is described by its accept edge, start levels and
  // targets; the level at any later edge is start moved by min(elapsed/STEP, distance).
  int m_edge;
  int m_ready;
  int m_start_edge;
  int m_maxd;
  int m_start [N];
  int m_tgt   [N];
  int m_lvl   [N];

  always @(posedge clk) begin
    if (!rst) begin
      m_edge  = 0;
      m_ready = 1;
      m_maxd  = 0;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0; m_tgt[i] = 0; m_start[i] = 0;
      end
    end else begin
      exp_t e;
      int   pwm_before;
      pwm_before = m_edge % (MAXL + 1);
      for (int i = 0; i < N; i++)
        e.leds[i] = (m_lvl[i] == MAXL) ? 1'b1 : (pwm_before < m_lvl[i]);
      m_edge++;
      if (m_ready == 1) begin
        if (pat_valid) begin
          m_start_edge = m_edge;
          m_maxd = 0;
          for (int i = 0; i < N; i++) begin
            int d;
            m_tgt[i]   = pat[i] ? MAXL : 0;
            m_start[i] = m_lvl[i];
            d = (m_tgt[i] > m_lvl[i]) ? m_tgt[i] - m_lvl[i] : m_lvl[i] - m_tgt[i];
            if (d > m_maxd) m_maxd = d;
          end
          if (m_maxd > 0) m_ready = 0;
        end
      end else begin
        int s;
        s = (m_edge - m_start_edge) / STEP;
        for (int i = 0; i < N; i++) begin
          int d;
          d = m_tgt[i] - m_start[i];
          if (d >= 0) m_lvl[i] = m_start[i] + ((s < d) ? s : d);
          else        m_lvl[i] = m_start[i] - ((s < -d) ? s : -d);
        end
        if (s >= m_maxd) m_ready = 1;
      end
      e.busy  = (m_ready == 0);
      e.ready = (m_ready == 1);
      sb_q.push_back(e);
    end
  end

  // Monitor: compares every registered output half a cycle after each edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("leds", int'(leds), int'(e.leds));
      check("busy", int'(busy), int'(e.busy));
      check("pat_ready", int'(pat_ready), int'(e.ready));
    end
  end

  task automatic send(input logic [N-1:0] p);
    int n;
    pat       = p;
    pat_valid = 1'b1;
    n = 0;
    while (!pat_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      total++; bad++;
      $display("FAIL send_timeout: pat_ready=%0b after %0d cycles, required 1", pat_ready, n);
    end
    @(negedge clk);
    pat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!pat_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      total++; bad++;
      $display("FAIL idle_timeout: pat_ready=%0b after %0d cycles, required 1", pat_ready, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", int'(leds), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(pat_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Fade up LED 0, then a request held during the fade.
    send(4'b0001);
    repeat (10) @(negedge clk);
    send(4'b1000);
    wait_idle();
    repeat (20) @(negedge clk);

    // Full on, then idempotent request.
    send(4'b1111);
    wait_idle();
    repeat (5) @(negedge clk);
    send(4'b1111);
    repeat (20) @(negedge clk);

    // Fade down, then cross-fade.
    send(4'b0000);
    wait_idle();
    send(4'b0011);
    wait_idle();
    send(4'b1100);
    wait_idle();
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-fade.
    send(4'b0011);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_leds", int'(leds), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(pat_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(4'b0000);
    repeat (8) @(negedge clk);
    send(4'b0110);
    wait_idle();

    // Randomized patterns, some offered during a fade.
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] p;
      p = N'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        wait_idle();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      send(p);
    end
    wait_idle();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
Downstream consumer of the random LED pattern generator. It accepts a new 4-bit on/off pattern through a valid/ready handshake. It then ramps each LED's brightness linearly toward its target (full on or full off) and drives the LED pins with per-LED PWM. The result replaces abrupt pattern changes on the board LEDs with smooth cross-fades.

Parameters:
N_LEDS, 4, number of LED channels (pattern width and leds width)
PWM_BITS, 8, width of brightness level and PWM counter; MAX = 2^PWM_BITS-1
STEP_CYCLES, 65536, clock cycles between brightness steps (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
pat  input  N_LEDS  requested pattern; bit i=1 -> LED i target MAX, 0 -> target 0
pat_valid  input  1  pattern offered this cycle
pat_ready  output  1  block can accept a pattern this cycle
busy  output  1  fade in progress
leds  output  N_LEDS  PWM-modulated LED drive, registered

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all level[i]=0, target latch=0, prescaler=0, pwm_cnt=0, leds=0, busy=0. pat_ready=1 while in IDLE, including during reset. No accept takes effect while rst=0.
- States: IDLE, FADE. pat_ready = (state==IDLE). busy = (state==FADE), registered.
- Accept: pat_valid && pat_ready at a rising edge. On accept, latch target[i] = pat[i] ? MAX : 0 and clear the prescaler.
  - If the latched target equals all current levels: stay IDLE, busy stays 0.
  - Otherwise: state=FADE and busy=1 from the next cycle.
- Non-accepted pat_valid cycles (pat_ready=0) are ignored. No buffering. The source must hold pat_valid until accepted.
- FADE:
  - Prescaler counts 0..STEP_CYCLES-1 and wraps.
  - On the wrap cycle, each level[i] != target[i] moves one step toward its target (+1 or -1). All channels step in the same cycle, independently.
  - When the step leaves every level equal to its target, state -> IDLE on that same edge. pat_ready=1 in the following cycle.
  - A fade from 0 to MAX therefore takes MAX*STEP_CYCLES cycles.
- Level arithmetic is saturating by construction. A level never passes its target and never wraps below 0 or above MAX.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps MAX->0 and is unaffected by the FSM.
  - leds[i] <= (level[i]==MAX) ? 1 : (pwm_cnt < level[i]).
  - Level 0 is constant off. MAX is constant on (no 1-cycle gap). Level L gives L high cycles per 2^PWM_BITS period.
  - One cycle of latency from level/pwm_cnt to leds.
- Reset mid-fade: levels, leds, busy and state clear immediately (asynchronously). The pending target is discarded.
- Simultaneous events: an accept is impossible in FADE, so a step and a new target never coincide.

Test Plan:
All scenarios use PWM_BITS=4 (MAX=15) and STEP_CYCLES=4 unless noted.
1. Reset: hold rst=0 for 3 cycles, release -> leds=0, busy=0, pat_ready=1. Pulse rst=0 asynchronously mid-fade -> leds and busy drop to 0 without waiting for a clock edge; all levels read 0 afterwards.
2. Fade up:
   - Accept pat=4'b0001 -> busy=1 next cycle; level[0] increments every 4 cycles.
   - After 60 cycles busy=0 and pat_ready=1; leds[0] is constant 1; leds[3:1] stay 0.
3. Handshake:
   - Assert pat_valid with pat=4'b1000 during a fade -> pat_ready=0, pattern ignored, levels unaffected.
   - Hold pat_valid -> accepted on the first IDLE cycle; leds[3] begins ramping.
4. PWM duty: stop a fade at level[1]=5 (set target 0101b from partial state, or probe the internal level) -> leds[1] is high exactly 5 of every 16 cycles, with 1-cycle latency versus pwm_cnt.
5. Idempotent request: after pattern 4'b1111 has settled, send 4'b1111 again -> accepted (pat_ready=1 that cycle), busy stays 0, leds unchanged.
6. Fade down and cross-fade:
   - From all levels=15, send 4'b0000 -> all four levels reach 0 together after 15 steps (60 cycles); leds=0.
   - From 4'b0011 settled, send 4'b1100 -> LEDs 0-1 ramp down while LEDs 2-3 ramp up; busy clears after 60 cycles.
